// File: rtl/fb_swap_arbiter.sv
// fb_swap_arbiter: ping-pong frame-buffer arbiter for the HDMI oscilloscope path.
// The trace writer fills the back bank (~addrSel) while scanout reads the front
// bank (addrSel). Banks swap only on vSync_up, after the back bank is complete.
// Optional feature macro: FB_AUTOCLEAR_EN. When it is defined, the new back bank
// is zeroed after every swap and after reset, before the writer is acknowledged.
module fb_swap_arbiter #(
  parameter int ADDR_WIDTH = 19,
  parameter int FRAME_SIZE = 307200
) (
  input  logic                  pixclk,
  input  logic                  rst,
  input  logic                  wrReq,
  input  logic                  wrData,
  output logic                  wrAck,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic                  rdData,
  input  logic                  vSync_up,
  input  logic                  RD0,
  input  logic                  RD1,
  output logic                  WE0,
  output logic                  WE1,
  output logic [ADDR_WIDTH-1:0] addrB0,
  output logic [ADDR_WIDTH-1:0] addrB1,
  output logic                  WD,
  output logic                  addrSel,
  output logic                  frame_written,
  output logic                  swapPending
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FULL  = 2'd1,
    ST_SWAP  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

`ifdef FB_AUTOCLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
  localparam state_t POST_SWAP   = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_FILL;
  localparam state_t POST_SWAP   = ST_FILL;
`endif

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  addr_sel_q, addr_sel_d;
  logic                  sel_d_q;
  logic                  rd_data_q, rd_data_d;
  logic                  frame_written_q, frame_written_d;

  logic                  we_back_s;
  logic                  wd_s;
  logic                  wr_ack_s;
  logic                  swap_pending_s;

  // Next-state and handshake decode of the fill/swap sequencer.
  always_comb begin
    state_d        = state_q;
    wr_addr_d      = wr_addr_q;
    we_back_s      = 1'b0;
    wd_s           = 1'b0;
    wr_ack_s       = 1'b0;
    swap_pending_s = 1'b0;
    case (state_q)
      ST_FILL: begin
        wr_ack_s = 1'b1;
        if (wrReq) begin
          we_back_s = 1'b1;
          wd_s      = wrData;
          // The final write parks the counter at the last address; vSync_up
          // in this same cycle is deliberately not honoured.
          if (wr_addr_q == LAST_ADDR) begin
            state_d = ST_FULL;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
          end
        end else begin
          we_back_s = 1'b0;
        end
      end
      ST_FULL: begin
        swap_pending_s = 1'b1;
        if (vSync_up) begin
          state_d = ST_SWAP;
        end else begin
          state_d = ST_FULL;
        end
      end
      ST_SWAP: begin
        wr_addr_d = '0;
        state_d   = POST_SWAP;
      end
`ifdef FB_AUTOCLEAR_EN
      ST_CLEAR: begin
        we_back_s = 1'b1;
        wd_s      = 1'b0;
        if (wr_addr_q == LAST_ADDR) begin
          wr_addr_d = '0;
          state_d   = ST_FILL;
        end else begin
          wr_addr_d = wr_addr_q + ADDR_ONE;
        end
      end
`endif
      default: begin
        state_d   = ST_FILL;
        wr_addr_d = '0;
      end
    endcase
  end

  // Swap bookkeeping: the displayed bank toggles and the swap pulse is raised
  // on the cycle after SWAP.
  always_comb begin
    addr_sel_d      = addr_sel_q;
    frame_written_d = 1'b0;
    if (state_q == ST_SWAP) begin
      addr_sel_d      = ~addr_sel_q;
      frame_written_d = 1'b1;
    end else begin
      addr_sel_d      = addr_sel_q;
      frame_written_d = 1'b0;
    end
  end

  // Read mux uses the bank select delayed by one cycle so it lines up with
  // the BRAM's one-cycle read latency, even across a swap.
  always_comb begin
    rd_data_d = 1'b0;
    if (sel_d_q) begin
      rd_data_d = RD1;
    end else begin
      rd_data_d = RD0;
    end
  end

  // State, counter, bank select and registered outputs.
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      state_q         <= RESET_STATE;
      wr_addr_q       <= '0;
      addr_sel_q      <= 1'b0;
      sel_d_q         <= 1'b0;
      rd_data_q       <= 1'b0;
      frame_written_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_addr_q       <= wr_addr_d;
      addr_sel_q      <= addr_sel_d;
      sel_d_q         <= addr_sel_q;
      rd_data_q       <= rd_data_d;
      frame_written_q <= frame_written_d;
    end
  end

  // Bank steering: the back bank takes the write counter, the front bank the
  // scanout address; write enables are held low throughout reset.
  assign WE0           = we_back_s & addr_sel_q & ~rst;
  assign WE1           = we_back_s & ~addr_sel_q & ~rst;
  assign addrB0        = addr_sel_q ? wr_addr_q : rdAddr;
  assign addrB1        = addr_sel_q ? rdAddr : wr_addr_q;
  assign WD            = wd_s;
  assign wrAck         = wr_ack_s & ~rst;
  assign swapPending   = swap_pending_s;
  assign addrSel       = addr_sel_q;
  assign frame_written = frame_written_q;
  assign rdData        = rd_data_q;

endmodule

// File: tb/tb_fb_swap_arbiter.sv
// Directed testbench for fb_swap_arbiter (default build, small 48-pixel frame).
module tb_fb_swap_arbiter;

  localparam int AW = 6;
  localparam int FS = 48;

  logic          pixclk = 1'b0;
  logic          rst;
  logic          wrReq, wrData, wrAck;
  logic [AW-1:0] rdAddr;
  logic          rdData;
  logic          vSync_up;
  logic          RD0, RD1;
  logic          WE0, WE1;
  logic [AW-1:0] addrB0, addrB1;
  logic          WD, addrSel, frame_written, swapPending;

  bit            bank0 [FS];
  bit            bank1 [FS];

  int n_checks = 0;
  int n_err    = 0;

  fb_swap_arbiter #(.ADDR_WIDTH(AW), .FRAME_SIZE(FS)) dut (
    .pixclk(pixclk), .rst(rst), .wrReq(wrReq), .wrData(wrData), .wrAck(wrAck),
    .rdAddr(rdAddr), .rdData(rdData), .vSync_up(vSync_up), .RD0(RD0), .RD1(RD1),
    .WE0(WE0), .WE1(WE1), .addrB0(addrB0), .addrB1(addrB1), .WD(WD),
    .addrSel(addrSel), .frame_written(frame_written), .swapPending(swapPending)
  );

  always #5 pixclk = ~pixclk;

  // Behavioural dual-port BRAMs, read-first, one-cycle read latency.
  always @(posedge pixclk) begin
    if (WE0) bank0[addrB0] <= WD;
    if (WE1) bank1[addrB1] <= WD;
    RD0 <= bank0[addrB0];
    RD1 <= bank1[addrB1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixclk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wrReq = 1'b0; wrData = 1'b0; rdAddr = '0; vSync_up = 1'b0;
    // Reset held for two cycles.
    tick(); tick();
    chk("rst_WE0", WE0, 0);
    chk("rst_WE1", WE1, 0);
    chk("rst_wrAck", wrAck, 0);
    chk("rst_addrSel", addrSel, 0);
    chk("rst_fw", frame_written, 0);
    chk("rst_swapPending", swapPending, 0);
    chk("rst_rdData", rdData, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_wrAck", wrAck, 1);

    // Fill bank 1 with alternating 1/0, early vSync after 20 writes.
    rdAddr = 6'd9;
    for (int i = 0; i < FS; i++) begin
      wrReq = 1'b1; wrData = (i % 2 == 0); vSync_up = (i == 20);
      #1;
      chk("fill1_WE1", WE1, 1);
      chk("fill1_WE0", WE0, 0);
      chk("fill1_addrB1", addrB1, i);
      chk("fill1_addrB0", addrB0, 9);
      chk("fill1_WD", WD, (i % 2 == 0) ? 1 : 0);
      chk("fill1_wrAck", wrAck, 1);
      chk("fill1_addrSel", addrSel, 0);
      chk("fill1_fw", frame_written, 0);
      tick();
    end
    vSync_up = 1'b0;
    #1;
    chk("full1_swapPending", swapPending, 1);
    chk("full1_wrAck", wrAck, 0);
    chk("full1_WE1", WE1, 0);
    chk("full1_WE0", WE0, 0);
    tick();
    chk("full1_hold", swapPending, 1);

    // Swap: vSync_up in FULL.
    wrReq = 1'b0; vSync_up = 1'b1;
    #1;
    tick();
    vSync_up = 1'b0;
    chk("swap1_n1_fw", frame_written, 0);
    chk("swap1_n1_addrSel", addrSel, 0);
    chk("swap1_n1_wrAck", wrAck, 0);
    chk("swap1_n1_swapPending", swapPending, 0);
    tick();
    chk("swap1_n2_fw", frame_written, 1);
    chk("swap1_n2_addrSel", addrSel, 1);
    chk("swap1_n2_wrAck", wrAck, 1);
    tick();
    chk("swap1_fw_pulse", frame_written, 0);

    // Read front bank 1 at addresses 4 and 5.
    rdAddr = 6'd4;
    #1;
    chk("rd1_addrB1", addrB1, 4);
    tick();
    rdAddr = 6'd5;
    tick();
    chk("rd1_data4", rdData, 1);
    tick();
    chk("rd1_data5", rdData, 0);

    // Partial frame into bank 0, then reset mid-frame.
    for (int i = 0; i < 10; i++) begin
      wrReq = 1'b1; wrData = 1'b1;
      #1;
      chk("part_WE0", WE0, 1);
      chk("part_WE1", WE1, 0);
      chk("part_addrB0", addrB0, i);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("midrst_WE0", WE0, 0);
    chk("midrst_WE1", WE1, 0);
    chk("midrst_wrAck", wrAck, 0);
    chk("midrst_addrSel", addrSel, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_rel_wrAck", wrAck, 1);
    chk("midrst_rel_addrB1", addrB1, 0);

    // Fill bank 1 again (1 where i%3==0), vSync_up coincides with write 47.
    rdAddr = 6'd7;
    for (int i = 0; i < FS; i++) begin
      wrReq = 1'b1; wrData = (i % 3 == 0); vSync_up = (i == FS - 1);
      #1;
      chk("fill2_WE1", WE1, 1);
      chk("fill2_WE0", WE0, 0);
      chk("fill2_addrB1", addrB1, i);
      chk("fill2_addrB0", addrB0, 7);
      tick();
    end
    vSync_up = 1'b0; wrReq = 1'b0;
    #1;
    chk("coll_swapPending", swapPending, 1);
    chk("coll_addrSel", addrSel, 0);
    chk("coll_fw", frame_written, 0);
    tick();
    chk("coll_hold_swapPending", swapPending, 1);
    chk("coll_hold_fw", frame_written, 0);
    chk("coll_hold_addrSel", addrSel, 0);

    // Next vSync_up performs the swap.
    vSync_up = 1'b1;
    tick();
    vSync_up = 1'b0;
    tick();
    chk("swap2_fw", frame_written, 1);
    chk("swap2_addrSel", addrSel, 1);
    chk("swap2_wrAck", wrAck, 1);

    // Read front bank 1 at addresses 3 and 4.
    rdAddr = 6'd3;
    tick();
    rdAddr = 6'd4;
    tick();
    chk("rd2_data3", rdData, 1);
    tick();
    chk("rd2_data4", rdData, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_swap_arbiter.md
# fb_swap_arbiter

Ping-pong frame-buffer arbiter for the HDMI oscilloscope path. It owns the two 1-bit pixel BRAM banks. It steers the trace writer into the back bank and the scanout reader into the front bank, and swaps the banks only during vertical blank so a partially drawn frame is never displayed. It sits between the waveform rasteriser (writer), the video timing generator (reader/vSync) and the two dual-port BRAMs.

## Interface
Parameters:
- ADDR_WIDTH, 19, bank address width (log2 of width*height, rounded up)
- FRAME_SIZE, 307200, pixels per frame (640*480); last write address is FRAME_SIZE-1

Ports:
- pixclk  in  1  pixel clock; sole clock of the block
- rst  in  1  asynchronous, active-high reset
- wrReq  in  1  writer presents a pixel
- wrData  in  1  pixel value to store
- wrAck  out  1  write accepted this cycle when wrReq && wrAck
- rdAddr  in  ADDR_WIDTH  scanout read address
- rdData  out  1  front-bank pixel, 2 cycles after rdAddr
- vSync_up  in  1  one-cycle pulse at start of vertical blank
- RD0, RD1  in  1  BRAM bank 0/1 read data (1-cycle synchronous read)
- WE0, WE1  out  1  bank write enables
- addrB0, addrB1  out  ADDR_WIDTH  bank addresses
- WD  out  1  shared bank write data
- addrSel  out  1  front (displayed) bank index
- frame_written  out  1  one-cycle pulse on swap
- swapPending  out  1  back bank complete, waiting for vSync_up

## Operation
- Back bank = ~addrSel. The front bank address is rdAddr. The back bank address is the internal write counter wrAddr.
- States:
  - FILL: wrAck=1. Each accepted write drives WE(back)=1, WD=wrData, addr=wrAddr, then wrAddr+1. The accepted write at wrAddr==FRAME_SIZE-1 moves the FSM to FULL and does not increment wrAddr.
  - FULL: wrAck=0, swapPending=1, writer stalls. On vSync_up the FSM moves to SWAP.
  - SWAP: single cycle. Toggle addrSel, pulse frame_written, wrAddr<=0. Next state is FILL, or CLEAR when the clear feature is compiled in.
  - CLEAR (feature only): wrAck=0. WE(back)=1, WD=0, wrAddr steps 0..FRAME_SIZE-1 one per cycle, then FILL with wrAddr=0.
- vSync_up in FILL or CLEAR is ignored. No swap occurs; the current front frame is shown again.
- If vSync_up arrives in the same cycle as the final FILL write, the write completes and the FSM enters FULL. The swap waits for the next vSync_up.
- The front bank is never written: WE(front)=0 in every state.
- Read path: a register captures addrSel each cycle (selD). rdData <= selD ? RD1 : RD0. This keeps the mux aligned with BRAM latency across a swap.
- wrAddr is ADDR_WIDTH wide; FRAME_SIZE-1 must fit, and there is no modulo wrap beyond FRAME_SIZE-1.

## Timing
- Reset values:
  - State FILL, or CLEAR with the feature.
  - wrAddr=0, addrSel=0, selD=0, rdData=0, frame_written=0, swapPending=0.
  - WE0=WE1=0 and wrAck=0 while rst is high.
- WE*, WD, addrB*, wrAck and swapPending are combinational decodes of registered state and inputs. frame_written and rdData are registered.
- Read latency: rdAddr at cycle N gives BRAM data at N+1 and rdData at N+2.
- Write: the address and data are presented in the same cycle as the handshake.
- Swap latency: vSync_up in FULL at cycle N; addrSel toggles and frame_written=1 at N+2 (N+1 is SWAP); wrAck=1 at N+2 without the feature.
- Reset mid-frame discards the back-bank contents. Display returns to bank 0.

## Configuration
- FB_AUTOCLEAR_EN defined: after every swap, and after reset, the new back bank is cleared over FRAME_SIZE cycles before wrAck rises. The writer only needs to draw set pixels.
- FB_AUTOCLEAR_EN undefined: there is no CLEAR state and SWAP goes directly to FILL. The writer must write every pixel of the frame.

## Test plan
FRAME_SIZE=48, ADDR_WIDTH=6 unless noted.
- Reset: hold rst for 2 cycles -> all outputs 0, addrSel=0; wrAck=1 after release (no macro).
- Fill: 48 writes of alternating 1/0 -> WE1 pulses on addrB1 0..47, WE0 never 1; swapPending=1 after write 47, then wrAck=0.
- Swap: vSync_up while in FULL -> frame_written pulse 2 cycles later, addrSel=1, wrAck=1; rdAddr=5 yields RD1 data 2 cycles later.
- Early vSync: vSync_up after 20 writes -> no swap, addrSel unchanged, filling continues to address 47.
- Collision: vSync_up in the cycle of write 47 -> no swap; the next vSync_up swaps.
- FB_AUTOCLEAR_EN: after the swap, 48 cycles of WE0=1 with WD=0 on addrB0 0..47 and wrAck=0, then wrAck=1. Also after reset, bank 1 is cleared first.
